// File: rtl/alu_operand_issuer.sv
// Issues one ALU operation at a time: optional split operand delivery with a gap, then waits out the ALU latency and holds the result.
// Optional ALU_ISSUER_ORDER_EN: a split request may send operand B before operand A.
module alu_operand_issuer #(
  parameter int DWIDTH   = 8,
  parameter int CWIDTH   = 4,
  parameter int MUL_CMD0 = 9,
  parameter int MUL_CMD1 = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [CWIDTH-1:0] req_cmd,
  input  logic              req_cin,
  input  logic [DWIDTH-1:0] req_opa,
  input  logic [DWIDTH-1:0] req_opb,
  input  logic              req_split,
  input  logic [3:0]        req_gap,
  input  logic              req_bfirst,
  output logic              ce,
  output logic              mode,
  output logic              cin,
  output logic [CWIDTH-1:0] cmd,
  output logic [DWIDTH-1:0] opa,
  output logic [DWIDTH-1:0] opb,
  output logic [1:0]        inp_valid,
  input  logic [DWIDTH:0]   res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH:0]   rsp_res
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_GAP, S_SECOND, S_WAIT, S_RESP
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                alive_reg;
  logic                mode_reg, cin_reg, split_reg, bfirst_reg;
  logic [CWIDTH-1:0]   cmd_reg;
  logic [DWIDTH-1:0]   opa_reg, opb_reg;
  logic [3:0]          gap_reg;
  logic [DWIDTH:0]     rsp_res_reg;
  logic                accept, capture, is_mul, active;
  logic [1:0]          first_code, second_code;
  logic [3:0]          lat_m1;

  assign accept = req_valid && req_ready;
  assign is_mul = mode_reg && ((cmd_reg == CWIDTH'(MUL_CMD0)) || (cmd_reg == CWIDTH'(MUL_CMD1)));
  assign lat_m1 = is_mul ? 4'd2 : 4'd0;

`ifdef ALU_ISSUER_ORDER_EN
  logic unused_bfirst_tie;
  assign unused_bfirst_tie = 1'b0;
  assign first_code  = (split_reg && bfirst_reg) ? 2'b10 : 2'b01;
  assign second_code = (split_reg && bfirst_reg) ? 2'b01 : 2'b10;
`else
  logic unused_bfirst;
  assign unused_bfirst = req_bfirst ^ bfirst_reg;
  assign first_code  = 2'b01;
  assign second_code = 2'b10;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      alive_reg   <= 1'b0;
      mode_reg    <= 1'b0;
      cin_reg     <= 1'b0;
      split_reg   <= 1'b0;
      bfirst_reg  <= 1'b0;
      cmd_reg     <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      gap_reg     <= '0;
      rsp_res_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      alive_reg <= 1'b1;
      if (accept) begin
        mode_reg  <= req_mode;
        cin_reg   <= req_cin;
        split_reg <= req_split;
`ifdef ALU_ISSUER_ORDER_EN
        bfirst_reg <= req_bfirst;
`else
        bfirst_reg <= 1'b0;
`endif
        cmd_reg   <= req_cmd;
        opa_reg   <= req_opa;
        opb_reg   <= req_opb;
        gap_reg   <= req_gap;
      end
      if (capture) rsp_res_reg <= res;
    end
  end

  // cnt_reg counts down remaining GAP or WAIT cycles; leaving at zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    inp_valid  = 2'b00;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_FIRST;
      end
      S_FIRST: begin
        if (!split_reg) begin
          inp_valid  = 2'b11;
          state_next = S_WAIT;
          cnt_next   = lat_m1;
        end else begin
          inp_valid = first_code;
          if (gap_reg != 4'd0) begin
            state_next = S_GAP;
            cnt_next   = gap_reg - 4'd1;
          end else begin
            state_next = S_SECOND;
          end
        end
      end
      S_GAP: begin
        if (cnt_reg == 4'd0) state_next = S_SECOND;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_SECOND: begin
        inp_valid  = second_code;
        state_next = S_WAIT;
        cnt_next   = lat_m1;
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign active    = (state_reg != S_IDLE);
  assign req_ready = (state_reg == S_IDLE) && alive_reg;
  assign ce        = active && (state_reg != S_RESP);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_res   = rsp_res_reg;
  assign mode      = active ? mode_reg : 1'b0;
  assign cin       = active ? cin_reg  : 1'b0;
  assign cmd       = active ? cmd_reg  : '0;
  assign opa       = active ? opa_reg  : '0;
  assign opb       = active ? opb_reg  : '0;

endmodule
